keypad_value_entry: RTL and testbench

Scans a 4x4 active-low matrix keypad, debounces it, decodes single key presses, and accumulates decimal digits into a 0–9999 binary entry value. It is the input-side counterpart to the scanned seven-segment display path. `entry` feeds the display driver's value input for live echo; `entered_value` and `enter_pulse` hand a committed number to the rest of the design.

---
 rtl/keypad_pkg.sv | 46 ++++
 rtl/keypad_value_entry_if.sv | 33 +++
 rtl/keypad_scanner.sv | 141 ++++++++++++++
 rtl/keypad_value_entry.sv | 70 +++++++
 tb/tb_keypad_value_entry.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared key codes, matrix lookup and press-FSM encoding
// for the keypad value entry path.
package keypad_pkg;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    typedef enum logic [1:0] {
        ST_LOCKOUT,
        ST_IDLE,
        ST_HELD
    } press_state_t;

    // Matrix position (row, column) to key code
    function automatic logic [3:0] key_lookup(
        input logic [1:0] r,
        input logic [1:0] c
    );
        logic [3:0] code;
        code = 4'd0;
        case ({r, c})
            4'h0: code = 4'd1;
            4'h1: code = 4'd2;
            4'h2: code = 4'd3;
            4'h3: code = KEY_A;
            4'h4: code = 4'd4;
            4'h5: code = 4'd5;
            4'h6: code = 4'd6;
            4'h7: code = KEY_B;
            4'h8: code = 4'd7;
            4'h9: code = 4'd8;
            4'hA: code = 4'd9;
            4'hB: code = KEY_C;
            4'hC: code = KEY_STAR;
            4'hD: code = 4'd0;
            4'hE: code = KEY_HASH;
            4'hF: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_value_entry_if.sv
// Keypad matrix pins plus the key/entry result bundle.
// master = keypad block, slave = keypad hardware and consumers.
interface keypad_value_entry_if;

    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [13:0] entry;
    logic [13:0] entered_value;
    logic        enter_pulse;

    modport master (
        output row,
        input  col,
        output key_valid,
        output key_code,
        output entry,
        output entered_value,
        output enter_pulse
    );

    modport slave (
        input  row,
        output col,
        input  key_valid,
        input  key_code,
        input  entry,
        input  entered_value,
        input  enter_pulse
    );

endinterface

// File: rtl/keypad_scanner.sv
// Row scan, column sync, frame debounce and single-press
// detection for a 4x4 active-low keypad matrix.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 50000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic       press,
    output logic [3:0] press_code,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int DW = $clog2(SCAN_CYCLES);
    localparam int MW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(DEBOUNCE_FRAMES - 1);

    logic [DW-1:0] dwell;
    logic [1:0]    ridx;
    logic [3:0]    col_s1;
    logic [3:0]    col_s2;
    logic [11:0]   frame_map;
    logic [15:0]   prev_map;
    logic [15:0]   stable_map;
    logic [MW-1:0] match_cnt;
    logic [MW-1:0] match_nxt;
    logic [15:0]   full_map;
    logic [3:0]    hit_idx;
    logic          tc;
    logic          frame_end;
    logic          accepted;
    logic          map_new;
    logic          map_zero;
    logic          single;

    press_state_t state_q;
    press_state_t state_d;

    assign row       = ~(4'b0001 << ridx);
    assign tc        = (dwell == DWELL_LAST);
    assign frame_end = tc && (ridx == 2'd3);
    // Row 3 is sampled in the frame-end cycle itself
    assign full_map  = {~col_s2, frame_map};
    assign map_zero  = (full_map == 16'd0);
    assign single    = !map_zero &&
                       ((full_map & (full_map - 16'd1)) == 16'd0);

    always_comb begin
        match_nxt = '0;
        if (full_map == prev_map) begin
            if (match_cnt == MATCH_LAST)
                match_nxt = match_cnt;
            else
                match_nxt = match_cnt + MW'(1);
        end
    end

    assign accepted = frame_end && (match_nxt == MATCH_LAST);
    assign map_new  = accepted && (full_map != stable_map);

    always_comb begin
        hit_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (full_map[i])
                hit_idx = 4'(i);
        end
    end

    assign press_code = key_lookup(hit_idx[3:2], hit_idx[1:0]);

    always_comb begin
        state_d = state_q;
        press   = 1'b0;
        unique case (state_q)
            ST_LOCKOUT: begin
                if (accepted && map_zero)
                    state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (map_new && !map_zero) begin
                    state_d = ST_HELD;
                    press   = single;
                end
            end
            ST_HELD: begin
                if (accepted && map_zero)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_LOCKOUT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_LOCKOUT;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell      <= '0;
            ridx       <= 2'd0;
            col_s1     <= 4'd0;
            col_s2     <= 4'd0;
            frame_map  <= 12'd0;
            prev_map   <= 16'd0;
            stable_map <= 16'd0;
            match_cnt  <= '0;
            key_valid  <= 1'b0;
            key_code   <= 4'd0;
        end else begin
            col_s1 <= col;
            col_s2 <= col_s1;
            if (tc) begin
                dwell <= '0;
                ridx  <= ridx + 2'd1;
            end else begin
                dwell <= dwell + DW'(1);
            end
            if (tc && (ridx != 2'd3))
                frame_map[{ridx, 2'b00} +: 4] <= ~col_s2;
            if (frame_end) begin
                prev_map  <= full_map;
                match_cnt <= match_nxt;
            end
            if (map_new)
                stable_map <= full_map;
            key_valid <= press;
            if (press)
                key_code <= press_code;
        end
    end

endmodule

// File: rtl/keypad_value_entry.sv
// Keypad front end: scanner plus decimal entry accumulator
// and commit registers for a 0..9999 value.
module keypad_value_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 50000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic clk,
    input  logic rst,
    keypad_value_entry_if.master bus
);

    logic        press;
    logic [3:0]  press_code;
    logic [13:0] entry_q;
    logic [13:0] entered_q;
    logic        pulse_q;
    logic [13:0] entry_x10;
    logic [13:0] entry_div10;

    keypad_scanner #(
        .SCAN_CYCLES    (SCAN_CYCLES),
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .row       (bus.row),
        .col       (bus.col),
        .press     (press),
        .press_code(press_code),
        .key_valid (bus.key_valid),
        .key_code  (bus.key_code)
    );

    // Only used while entry <= 999, so the shifts cannot overflow
    assign entry_x10   = {entry_q[10:0], 3'b000} + {entry_q[12:0], 1'b0};
    assign entry_div10 = entry_q / 14'd10;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q   <= 14'd0;
            entered_q <= 14'd0;
            pulse_q   <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (press) begin
                unique case (1'b1)
                    (press_code <= 4'd9): begin
                        if (entry_q <= 14'd999)
                            entry_q <= entry_x10 + {10'd0, press_code};
                    end
                    (press_code == KEY_STAR): entry_q <= entry_div10;
                    (press_code == KEY_HASH): begin
                        entered_q <= entry_q;
                        pulse_q   <= 1'b1;
                        entry_q   <= 14'd0;
                    end
                    (press_code == KEY_D): entry_q <= 14'd0;
                    default: ;
                endcase
            end
        end
    end

    assign bus.entry         = entry_q;
    assign bus.entered_value = entered_q;
    assign bus.enter_pulse   = pulse_q;

endmodule

// File: tb/tb_keypad_value_entry.sv
// Bench for keypad_value_entry: matrix key model, random and
// directed presses, event-level reference model.
module tb_keypad_value_entry;

    localparam int SC      = 4;
    localparam int DF      = 2;
    localparam int LAT_MAX = (DF + 1) * 4 * SC + 3;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic [15:0] keys = 16'd0;

    // Matrix bit index (row*4+col) of each key code
    int pos [16] = '{13, 0, 1, 2, 4, 5, 6, 8,
                     9, 10, 3, 7, 11, 15, 12, 14};

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int m_entry   = 0;
    int m_entered = 0;
    int m_code    = 0;
    int exp_q [$];
    int dl_q  [$];
    int cc, dd, ep;

    keypad_value_entry_if bus();

    keypad_value_entry #(
        .SCAN_CYCLES    (SC),
        .DEBOUNCE_FRAMES(DF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A pressed key shorts its column to the driven (low) row
    always_comb begin
        bus.col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!bus.row[r] && keys[r*4+c])
                    bus.col[c] = 1'b0;
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, got, exp, $time);
        end
    endtask

    task automatic apply(input int c);
        m_code = c;
        if (c <= 9) begin
            if (m_entry <= 999)
                m_entry = m_entry * 10 + c;
        end else if (c == 14) begin
            m_entry = m_entry / 10;
        end else if (c == 15) begin
            m_entered = m_entry;
            m_entry   = 0;
        end else if (c == 13) begin
            m_entry = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            ep = 0;
            if (bus.key_valid) begin
                chk("event_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    cc = exp_q.pop_front();
                    dd = dl_q.pop_front();
                    chk("key_code_event", int'(bus.key_code), cc);
                    chk("event_late_by", (cyc > dd) ? cyc - dd : 0, 0);
                    apply(cc);
                    ep = (cc == 15) ? 1 : 0;
                end
            end else begin
                chk("key_code_hold", int'(bus.key_code), m_code);
            end
            chk("entry", int'(bus.entry), m_entry);
            chk("entered_value", int'(bus.entered_value), m_entered);
            chk("enter_pulse", int'(bus.enter_pulse), ep);
            chk("row_onehot_low", $countones(~bus.row), 1);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_row", int'(bus.row), 14);
        chk("rst_key_valid", int'(bus.key_valid), 0);
        chk("rst_key_code", int'(bus.key_code), 0);
        chk("rst_entry", int'(bus.entry), 0);
        chk("rst_entered", int'(bus.entered_value), 0);
        chk("rst_pulse", int'(bus.enter_pulse), 0);
        m_entry   = 0;
        m_entered = 0;
        m_code    = 0;
        exp_q.delete();
        dl_q.delete();
        wait_cyc(3);
        rst = 1'b0;
    endtask

    task automatic press(input int code, input int hold,
                         input int gap, input int bounce);
        exp_q.push_back(code);
        dl_q.push_back(cyc + bounce + LAT_MAX);
        for (int i = 0; i < bounce; i++) begin
            keys[pos[code]] = ((i / 3) % 2 == 0);
            @(negedge clk);
        end
        keys[pos[code]] = 1'b1;
        wait_cyc(hold);
        chk("event_seen", exp_q.size(), 0);
        keys[pos[code]] = 1'b0;
        wait_cyc(gap);
    endtask

    task automatic tap(input int code);
        press(code, 64, 64, 0);
    endtask

    initial begin
        int code, hold, gap, bnc;
        do_reset();
        wait_cyc(64);

        tap(1);
        chk("lit_entry_1", int'(bus.entry), 1);
        tap(2);
        chk("lit_entry_12", int'(bus.entry), 12);
        tap(3);
        chk("lit_entry_123", int'(bus.entry), 123);
        tap(4);
        chk("lit_entry_1234", int'(bus.entry), 1234);
        chk("model_1234", m_entry, 1234);

        tap(13);
        for (int i = 0; i < 4; i++) tap(9);
        tap(5);
        chk("lit_entry_9999", int'(bus.entry), 9999);
        chk("lit_code_5", int'(bus.key_code), 5);
        tap(15);
        chk("lit_entered_9999", int'(bus.entered_value), 9999);
        chk("lit_entry_cleared", int'(bus.entry), 0);

        tap(1); tap(2); tap(3);
        tap(14);
        chk("lit_bs_12", int'(bus.entry), 12);
        tap(14);
        chk("lit_bs_1", int'(bus.entry), 1);
        tap(13);
        chk("lit_clear_0", int'(bus.entry), 0);
        tap(14);
        chk("lit_bs_at_0", int'(bus.entry), 0);

        press(7, 80, 64, 20);
        chk("lit_bounce_7", int'(bus.entry), 7);

        keys[pos[2]] = 1'b1;
        keys[pos[5]] = 1'b1;
        wait_cyc(80);
        keys[pos[5]] = 1'b0;
        wait_cyc(80);
        keys[pos[2]] = 1'b0;
        wait_cyc(80);
        chk("lit_multi_none", int'(bus.entry), 7);
        tap(5);
        chk("lit_entry_75", int'(bus.entry), 75);

        keys[pos[8]] = 1'b1;
        do_reset();
        wait_cyc(120);
        keys[pos[8]] = 1'b0;
        wait_cyc(80);
        chk("lit_lockout_0", int'(bus.entry), 0);
        tap(8);
        chk("lit_entry_8", int'(bus.entry), 8);

        for (int n = 0; n < 30; n++) begin
            code = int'($urandom_range(0, 15));
            hold = 64 + int'($urandom_range(0, 30));
            gap  = 64 + int'($urandom_range(0, 30));
            bnc  = ($urandom_range(0, 1) == 1) ?
                   int'($urandom_range(6, 18)) : 0;
            press(code, hold, gap, bnc);
        end

        wait_cyc(20);
        chk("events_pending", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
